// File: rtl/systolic_mem_pkg.sv
// -----------------------------------------------------------------------------
// systolic_mem_pkg
// Shared types for the memory tile fetcher and its output byte FIFO.
//   addr_t        : default-width memory byte address
//   dim_t         : default-width tile dimension / counter
//   fetch_state_t : fetcher FSM states (IDLE, FETCH, DRAIN, DONE)
//   fifo_entry_t  : one buffered tile byte with its row/tile end markers
// -----------------------------------------------------------------------------
package systolic_mem_pkg;

    localparam int ADDRESS_WIDTH_DEF = 32;
    localparam int DIM_WIDTH_DEF     = 8;

    typedef logic [ADDRESS_WIDTH_DEF-1:0] addr_t;
    typedef logic [DIM_WIDTH_DEF-1:0]     dim_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       row_last;
        logic       last;
    } fifo_entry_t;

endpackage

// File: rtl/mem_tile_fetcher_if.sv
// -----------------------------------------------------------------------------
// mem_tile_fetcher_if
// Bundles the two buses of the tile fetcher:
//   memory port : mem_address, mem_re, mem_we, mem_be, mem_write_data (to
//                 memory), mem_read_data (combinational, from memory)
//   tile stream : out_data, out_valid, out_row_last, out_last (to feeder),
//                 out_ready (from feeder)
// Modports: master = fetcher side, slave = memory + feeder side.
//
// Stream handshake: a byte transfers on a rising clk edge where
// out_valid && out_ready. Once out_valid is high it stays high, and out_data,
// out_row_last and out_last stay unchanged, until that transfer happens.
// out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
interface mem_tile_fetcher_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic                     mem_re;
    logic                     mem_we;
    logic                     mem_be;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic [DATA_WIDTH-1:0]    mem_read_data;

    logic [7:0]               out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_row_last;
    logic                     out_last;

    modport master (
        output mem_address, mem_re, mem_we, mem_be, mem_write_data,
        input  mem_read_data,
        output out_data, out_valid, out_row_last, out_last,
        input  out_ready
    );

    modport slave (
        input  mem_address, mem_re, mem_we, mem_be, mem_write_data,
        output mem_read_data,
        input  out_data, out_valid, out_row_last, out_last,
        output out_ready
    );
endinterface

// File: rtl/byte_stream_fifo.sv
// -----------------------------------------------------------------------------
// byte_stream_fifo
// Synchronous FIFO of fifo_entry_t, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write din at posedge (caller never pushes when full)
//   pop          : drop the head entry at posedge (ignored when empty)
//   head         : current head entry (valid when !empty)
//   full, empty  : occupancy flags
// Push and pop in the same cycle leave the occupancy unchanged.
// -----------------------------------------------------------------------------
module byte_stream_fifo
    import systolic_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        full,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);

    fifo_entry_t   store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic do_push;
    logic do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    // Storage needs no reset: nothing reads it while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mem_tile_fetcher.sv
// -----------------------------------------------------------------------------
// mem_tile_fetcher
// Reads a rows x cols byte tile (row pitch = stride bytes) from a byte-read
// memory port and streams it row-major to the systolic array feeder.
// A small FIFO decouples memory reads from consumer stalls.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : launch a fetch (sampled only in IDLE)
//   base_addr, rows, cols,
//   stride                : tile geometry, latched at start
//   busy                  : high from the cycle after start until done
//   done                  : one-cycle pulse once the tile is fully delivered
//   state_dbg             : current FSM state
//   bus (master)          : memory port + tile output stream
//   perf_reads/perf_stalls: only with FETCH_PERF_EN defined; count of read
//                           cycles and of FETCH cycles blocked by a full FIFO
// Optional build macro: FETCH_PERF_EN.
// -----------------------------------------------------------------------------
module mem_tile_fetcher
    import systolic_mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DIM_WIDTH     = DIM_WIDTH_DEF,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]     rows,
    input  logic [DIM_WIDTH-1:0]     cols,
    input  logic [ADDRESS_WIDTH-1:0] stride,
    output logic                     busy,
    output logic                     done,
    output fetch_state_t             state_dbg,
    mem_tile_fetcher_if.master       bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_reads,
    output logic [31:0]              perf_stalls
`endif
);
    fetch_state_t             state;
    logic [ADDRESS_WIDTH-1:0] row_base;
    logic [ADDRESS_WIDTH-1:0] stride_q;
    logic [DIM_WIDTH-1:0]     rows_q;
    logic [DIM_WIDTH-1:0]     cols_q;
    logic [DIM_WIDTH-1:0]     row;
    logic [DIM_WIDTH-1:0]     col;

    logic        fifo_full;
    logic        fifo_empty;
    fifo_entry_t fifo_head;
    fifo_entry_t push_entry;

    logic issue;
    logic col_end;
    logic row_end;
    logic pop;

    // Only the low byte of the read bus carries data.
    logic [DATA_WIDTH-1:0] unused_read_bits;
    assign unused_read_bits = bus.mem_read_data;

    // A read is issued every FETCH cycle that the FIFO has room for the byte.
    assign issue   = (state == FETCH) && !fifo_full;
    assign col_end = (col == cols_q - DIM_WIDTH'(1));
    assign row_end = (row == rows_q - DIM_WIDTH'(1));
    assign pop     = !fifo_empty && bus.out_ready;

    assign push_entry.data     = bus.mem_read_data[7:0];
    assign push_entry.row_last = col_end;
    assign push_entry.last     = col_end && row_end;

    assign bus.mem_re         = issue;
    assign bus.mem_address    = issue ? (row_base + ADDRESS_WIDTH'(col)) : '0;
    assign bus.mem_we         = 1'b0;
    assign bus.mem_be         = 1'b1;
    assign bus.mem_write_data = '0;

    // Output fields are forced to 0 while nothing is buffered so the stream
    // reads as idle after reset.
    assign bus.out_valid    = !fifo_empty;
    assign bus.out_data     = fifo_empty ? 8'h00 : fifo_head.data;
    assign bus.out_row_last = !fifo_empty && fifo_head.row_last;
    assign bus.out_last     = !fifo_empty && fifo_head.last;

    assign state_dbg = state;

    byte_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (issue),
        .din     (push_entry),
        .pop     (pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            row_base <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            row      <= '0;
            col      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        row_base <= base_addr;
                        stride_q <= stride;
                        rows_q   <= rows;
                        cols_q   <= cols;
                        row      <= '0;
                        col      <= '0;
                        busy     <= 1'b1;
                        // An empty tile skips straight to completion.
                        if ((rows == '0) || (cols == '0)) begin
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        if (col_end) begin
                            // Row advance by accumulating the pitch.
                            col      <= '0;
                            row      <= row + DIM_WIDTH'(1);
                            row_base <= row_base + stride_q;
                            if (row_end) begin
                                state <= DRAIN;
                            end
                        end else begin
                            col <= col + DIM_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The last-tagged entry is the final one in the FIFO, so
                    // its handshake also leaves the FIFO empty.
                    if (pop && fifo_head.last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_reads  <= '0;
            perf_stalls <= '0;
        end else if ((state == IDLE) && start) begin
            perf_reads  <= '0;
            perf_stalls <= '0;
        end else begin
            if (issue && (perf_reads != '1)) begin
                perf_reads <= perf_reads + 32'd1;
            end
            if ((state == FETCH) && fifo_full && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_tile_fetcher.sv
// -----------------------------------------------------------------------------
// tb_mem_tile_fetcher
// Directed bench for mem_tile_fetcher: byte-addressed memory model, negedge
// monitor logging read addresses, accepted stream bytes and done pulses, and
// one task per scenario with inline comparisons against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_tile_fetcher;
    import systolic_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic         start;
    addr_t        base_addr;
    dim_t         rows;
    dim_t         cols;
    addr_t        stride;
    logic         busy;
    logic         done;
    fetch_state_t state_dbg;
`ifdef FETCH_PERF_EN
    logic [31:0]  perf_reads;
    logic [31:0]  perf_stalls;
`endif

    mem_tile_fetcher_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    mem_tile_fetcher #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .DIM_WIDTH     (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .rows      (rows),
        .cols      (cols),
        .stride    (stride),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg),
        .bus       (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_reads  (perf_reads),
        .perf_stalls (perf_stalls)
`endif
    );

    // ---------------- memory model: 4 KiB of bytes, 0 beyond ----------------
    logic [7:0]  mem_bytes [4096];
    logic [31:0] rd_word;
    always_comb begin
        rd_word = 32'h0;
        if (bus.mem_address < 32'd4096) begin
            rd_word = {24'h0, mem_bytes[bus.mem_address[11:0]]};
        end
    end
    assign bus.mem_read_data = rd_word;

    // ---------------- monitor / scoreboard ----------------
    int          errors;
    int          checks;
    int          cyc;
    int          done_cnt;
    int          done_cyc;
    int          last_cyc;
    int          first_cyc;
    addr_t       addr_log [$];
    logic [9:0]  byte_log [$];   // {last, row_last, data}
    logic [9:0]  exp_q [$];
    addr_t       exp_addr_q [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.mem_re) begin
            addr_log.push_back(bus.mem_address);
        end
        if (bus.out_valid && bus.out_ready) begin
            if (byte_log.size() == 0) first_cyc = cyc;
            byte_log.push_back({bus.out_last, bus.out_row_last, bus.out_data});
            if (bus.out_last) last_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    int start_cyc;

    task automatic clear_logs();
        addr_log.delete();
        byte_log.delete();
        exp_q.delete();
        exp_addr_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_cyc = -1;
        first_cyc = -1;
    endtask

    // Raises start for exactly one posedge; returns #1 after that edge.
    task automatic start_fetch(input addr_t b, input dim_t r, input dim_t c, input addr_t s);
        @(posedge clk);
        #1;
        base_addr = b;
        rows      = r;
        cols      = c;
        stride    = s;
        start     = 1'b1;
        @(posedge clk);
        start_cyc = cyc;
        #1;
        start = 1'b0;
    endtask

    // Waits up to max_cycles for a done pulse; a timeout counts as a failure.
    task automatic wait_done(input int max_cycles);
        int base_cnt;
        bit seen;
        base_cnt = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base_cnt) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", max_cycles);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++;
        if ({bus.mem_re, bus.out_valid, bus.out_last, bus.out_row_last, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.mem_re, bus.out_valid, bus.out_last, bus.out_row_last, busy, done});
        end
        checks++;
        if (bus.mem_address !== 32'h0 || bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: addr=%0h data=%0h expected 0 0", bus.mem_address, bus.out_data);
        end
        checks++;
        if (state_dbg !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE);
        end
    endtask

    task automatic test_single_row();
        clear_logs();
        mem_bytes[12'h100] = 8'h11;
        mem_bytes[12'h101] = 8'h22;
        mem_bytes[12'h102] = 8'h33;
        mem_bytes[12'h103] = 8'h44;
        exp_q = '{10'h011, 10'h022, 10'h033, 10'h344};
        bus.out_ready = 1'b1;
        start_fetch(32'h100, 8'd1, 8'd4, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.mem_re !== 1'b1 || bus.mem_address !== 32'h100 || bus.out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_read: re=%b addr=%0h valid=%b busy=%b expected 1 100 0 1",
                     bus.mem_re, bus.mem_address, bus.out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
            errors++;
            $display("FAIL first_byte: valid=%b data=%0h expected 1 11", bus.out_valid, bus.out_data);
        end
        wait_done(50);
        checks++;
        if (byte_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL row_count: got %0d bytes expected %0d", byte_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (byte_log[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL row_byte[%0d]: got %0h expected %0h", i, byte_log[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (done_cyc - last_cyc != 2) begin
            errors++;
            $display("FAIL done_latency: got %0d expected 2", done_cyc - last_cyc);
        end
        checks++;
        if (last_cyc - first_cyc != 3) begin
            errors++;
            $display("FAIL throughput: span %0d expected 3", last_cyc - first_cyc);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL after_done: busy=%b done=%b pulses=%0d expected 0 0 1", busy, done, done_cnt);
        end
    endtask

    task automatic test_stride();
        clear_logs();
        mem_bytes[12'h200] = 8'hA0;
        mem_bytes[12'h201] = 8'hA1;
        mem_bytes[12'h210] = 8'hB0;
        mem_bytes[12'h211] = 8'hB1;
        mem_bytes[12'h220] = 8'hC0;
        mem_bytes[12'h221] = 8'hC1;
        exp_addr_q = '{32'h200, 32'h201, 32'h210, 32'h211, 32'h220, 32'h221};
        exp_q = '{10'h0A0, 10'h1A1, 10'h0B0, 10'h1B1, 10'h0C0, 10'h3C1};
        bus.out_ready = 1'b1;
        start_fetch(32'h200, 8'd3, 8'd2, 32'h10);
        wait_done(60);
        checks++;
        if (addr_log.size() != exp_addr_q.size()) begin
            errors++;
            $display("FAIL stride_reads: got %0d expected %0d", addr_log.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                if (addr_log[i] !== exp_addr_q[i]) begin
                    errors++;
                    $display("FAIL stride_addr[%0d]: got %0h expected %0h", i, addr_log[i], exp_addr_q[i]);
                end
            end
        end
        checks++;
        if (byte_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stride_count: got %0d expected %0d", byte_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (byte_log[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL stride_byte[%0d]: got %0h expected %0h", i, byte_log[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            mem_bytes[12'h500 + i] = 8'h50 + 8'(i);
            mem_bytes[12'h508 + i] = 8'h60 + 8'(i);
        end
        exp_q = '{10'h050, 10'h051, 10'h052, 10'h153, 10'h060, 10'h061, 10'h062, 10'h363};
        bus.out_ready = 1'b0;
        start_fetch(32'h500, 8'd2, 8'd4, 32'h8);
        repeat (10) @(negedge clk);
        checks++;
        if (addr_log.size() != 4) begin
            errors++;
            $display("FAIL stall_reads: got %0d expected 4", addr_log.size());
        end
        checks++;
        if (bus.mem_re !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h50) begin
            errors++;
            $display("FAIL stall_hold: re=%b valid=%b data=%0h expected 0 1 50",
                     bus.mem_re, bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        checks++;
        if (bus.out_data !== 8'h50 || bus.out_row_last !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL stall_stable: data=%0h rl=%b l=%b expected 50 0 0",
                     bus.out_data, bus.out_row_last, bus.out_last);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done(80);
        checks++;
        if (byte_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d expected %0d", byte_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (byte_log[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL stall_byte[%0d]: got %0h expected %0h", i, byte_log[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (addr_log.size() != 8 || addr_log[4] !== 32'h508) begin
            errors++;
            $display("FAIL stall_total_reads: got %0d reads expected 8 (row 1 at 508)", addr_log.size());
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_reads !== 32'd8 || perf_stalls == 32'd0) begin
            errors++;
            $display("FAIL perf: reads=%0d stalls=%0d expected 8 and nonzero", perf_reads, perf_stalls);
        end
`endif
    endtask

    task automatic test_empty_tile();
        clear_logs();
        bus.out_ready = 1'b1;
        start_fetch(32'h100, 8'd0, 8'd5, 32'h0);
        wait_done(20);
        checks++;
        if (addr_log.size() != 0 || byte_log.size() != 0) begin
            errors++;
            $display("FAIL empty_reads: reads=%0d bytes=%0d expected 0 0", addr_log.size(), byte_log.size());
        end
        checks++;
        if (done_cyc - start_cyc != 2) begin
            errors++;
            $display("FAIL empty_done_latency: got %0d expected 2", done_cyc - start_cyc);
        end
    endtask

    task automatic test_reset_mid_fetch();
        clear_logs();
        bus.out_ready = 1'b0;
        start_fetch(32'h600, 8'd2, 8'd4, 32'h8);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_re, bus.out_valid, bus.out_last, bus.out_row_last, busy, done} !== 6'b0 ||
            bus.mem_address !== 32'h0 || bus.out_data !== 8'h00 || state_dbg !== IDLE) begin
            errors++;
            $display("FAIL midreset_outputs: flags=%b addr=%0h data=%0h state=%0d expected all 0",
                     {bus.mem_re, bus.out_valid, bus.out_last, bus.out_row_last, busy, done},
                     bus.mem_address, bus.out_data, state_dbg);
        end
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        clear_logs();
        mem_bytes[12'h300] = 8'h31;
        mem_bytes[12'h301] = 8'h32;
        mem_bytes[12'h302] = 8'h33;
        exp_addr_q = '{32'h300, 32'h301, 32'h302};
        exp_q = '{10'h031, 10'h032, 10'h333};
        bus.out_ready = 1'b1;
        start_fetch(32'h300, 8'd1, 8'd3, 32'h0);
        wait_done(40);
        checks++;
        if (addr_log.size() != 3 || addr_log[0] !== exp_addr_q[0] || addr_log[1] !== exp_addr_q[1] ||
            addr_log[2] !== exp_addr_q[2]) begin
            errors++;
            $display("FAIL post_reset_addr: got %0d reads first=%0h expected 3 from 300",
                     addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 32'h0);
        end
        checks++;
        if (byte_log.size() != 3 || byte_log[0] !== exp_q[0] || byte_log[1] !== exp_q[1] ||
            byte_log[2] !== exp_q[2]) begin
            errors++;
            $display("FAIL post_reset_bytes: got %0d bytes first=%0h expected 3 starting 031",
                     byte_log.size(), (byte_log.size() > 0) ? byte_log[0] : 10'h0);
        end
    endtask

    task automatic test_start_while_busy();
        bit hit_400;
        clear_logs();
        mem_bytes[12'h400] = 8'hEE;
        mem_bytes[12'h700] = 8'h70;
        mem_bytes[12'h701] = 8'h71;
        mem_bytes[12'h708] = 8'h78;
        mem_bytes[12'h709] = 8'h79;
        exp_addr_q = '{32'h700, 32'h701, 32'h708, 32'h709};
        exp_q = '{10'h070, 10'h171, 10'h078, 10'h379};
        bus.out_ready = 1'b1;
        start_fetch(32'h700, 8'd2, 8'd2, 32'h8);
        @(posedge clk);
        #1;
        base_addr = 32'h400;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40);
        repeat (6) @(negedge clk);
        #1;
        hit_400 = 1'b0;
        foreach (addr_log[i]) begin
            if (addr_log[i][31:8] == 24'h4) hit_400 = 1'b1;
        end
        checks++;
        if (hit_400 || addr_log.size() != exp_addr_q.size()) begin
            errors++;
            $display("FAIL busy_start_reads: reads=%0d touched_400=%b expected 4 0", addr_log.size(), hit_400);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start_done: got %0d pulses expected 1", done_cnt);
        end
        checks++;
        if (byte_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL busy_start_count: got %0d expected %0d", byte_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (byte_log[i] !== exp_q[i] || addr_log[i] !== exp_addr_q[i]) begin
                    errors++;
                    $display("FAIL busy_start_item[%0d]: byte %0h addr %0h expected %0h %0h",
                             i, byte_log[i], addr_log[i], exp_q[i], exp_addr_q[i]);
                end
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        errors        = 0;
        checks        = 0;
        cyc           = 0;
        reset_n       = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        rows          = '0;
        cols          = '0;
        stride        = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem_bytes[i] = 8'h00;
        clear_logs();
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;

        test_single_row();
        test_stride();
        test_backpressure();
        test_empty_tile();
        test_reset_mid_fetch();
        test_start_while_busy();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
